// File: rtl/freq_detect_pkg.sv
// Shared types and widths for the channel-1 peak-bin detector and its helpers.
package freq_detect_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 28;
    localparam int HALF_W = 14;
    localparam int PWR_W  = 29;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

endpackage

// File: rtl/fd_magsq.sv
// Squared magnitude of a packed complex word {re[13:0], im[13:0]}, both signed.
module fd_magsq
    import freq_detect_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    output logic [PWR_W-1:0]  magsq_o
);

    logic signed [2*HALF_W-1:0] re_x, im_x, re_sq, im_sq;

    // Sign-extend before multiplying; each square is at most 2^26, so the sum fits in 29 bits.
    assign re_x  = {{HALF_W{word_i[DATA_W-1]}}, word_i[DATA_W-1:HALF_W]};
    assign im_x  = {{HALF_W{word_i[HALF_W-1]}}, word_i[HALF_W-1:0]};
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;

    assign magsq_o = {1'b0, re_sq} + {1'b0, im_sq};

endmodule

// File: rtl/freq_detect.sv
// Scans channel-1 FFT RAM for the bin of maximum power, then parks rdaddr1 on it.
// Optional FREQ_DETECT_THRESH_EN adds a power threshold (thresh) and a nodetect pulse.
module freq_detect
    import freq_detect_pkg::*;
#(
    parameter int unsigned BIN_LO = 1,
    parameter int unsigned BIN_HI = 511,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fftdone,
    input  logic [DATA_W-1:0] ramq1,
`ifdef FREQ_DETECT_THRESH_EN
    input  logic [PWR_W-1:0]  thresh,
    output logic              nodetect,
`endif
    output logic [ADDR_W-1:0] rdaddr1,
    output logic [ADDR_W-1:0] maxbin,
    output logic [PWR_W-1:0]  maxpwr,
    output logic              detectdone,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LO = ADDR_W'(BIN_LO);
    localparam logic [ADDR_W-1:0] HI = ADDR_W'(BIN_HI);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [ADDR_W-1:0] bin_q [RD_LAT];
    logic [ADDR_W-1:0] bin_d [RD_LAT];
    logic [PWR_W-1:0]  run_pwr_q, run_pwr_d, maxpwr_q, magsq;
    logic [ADDR_W-1:0] run_bin_q, run_bin_d, maxbin_q;
    logic              detect_q, nodet_q, busy_q, accept;

    fd_magsq u_magsq (.word_i(ramq1), .magsq_o(magsq));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = (state_q == SCAN);
        bin_d[0] = addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            bin_d[i] = bin_q[i-1];
        end
    end

    // Strict compare keeps the lowest bin on ties.
    always_comb begin
        run_pwr_d = run_pwr_q;
        run_bin_d = run_bin_q;
        if (vld_q[RD_LAT-1] && (magsq > run_pwr_q)) begin
            run_pwr_d = magsq;
            run_bin_d = bin_q[RD_LAT-1];
        end
    end

`ifdef FREQ_DETECT_THRESH_EN
    assign accept   = (run_pwr_d >= thresh);
    assign nodetect = nodet_q;
`else
    assign accept   = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            vld_q     <= '0;
            run_pwr_q <= '0;
            run_bin_q <= '0;
            maxbin_q  <= '0;
            maxpwr_q  <= '0;
            detect_q  <= 1'b0;
            nodet_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            run_pwr_q <= run_pwr_d;
            run_bin_q <= run_bin_d;
            detect_q  <= 1'b0;
            nodet_q   <= 1'b0;
            case (state_q)
                IDLE: if (fftdone) begin
                    state_q   <= SCAN;
                    addr_q    <= LO;
                    run_pwr_q <= '0;
                    run_bin_q <= LO;
                    busy_q    <= 1'b1;
                end
                SCAN: begin
                    if (addr_q == HI) state_q <= DRAIN;
                    else              addr_q  <= addr_q + 1'b1;
                end
                DRAIN: if (vld_d == '0) begin
                    // The last returned word is folded in via run_*_d on this same edge.
                    state_q <= DONE;
                    if (accept) begin
                        maxbin_q <= run_bin_d;
                        maxpwr_q <= run_pwr_d;
                        addr_q   <= run_bin_d;
                        detect_q <= 1'b1;
                    end else begin
                        addr_q  <= maxbin_q;
                        nodet_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the bin pipe is not reset; its contents are only consumed when the matching valid bit is set.
    always_ff @(posedge clk) begin
        bin_q <= bin_d;
    end

    assign rdaddr1    = addr_q;
    assign maxbin     = maxbin_q;
    assign maxpwr     = maxpwr_q;
    assign detectdone = detect_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_freq_detect.sv
// Bench for freq_detect: two instances (RD_LAT 1 and 2) against a frame-level model plus directed literals.
module tb_freq_detect;

    localparam int LO = 1;
    localparam int HI = 511;
    localparam int N  = HI - LO + 1;

    logic        clk = 1'b0;
    logic        reset, fftdone;
    logic [28:0] thresh;
    logic [27:0] mem [1024];
    int          fr_re [1024];
    int          fr_im [1024];

    logic [27:0] q_a, q_b, q_b_p;
    logic [9:0]  rd_a, rd_b, bin_a, bin_b;
    logic [28:0] pwr_a, pwr_b;
    logic        done_a, done_b, busy_a, busy_b, nod_a, nod_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    freq_detect #(.BIN_LO(LO), .BIN_HI(HI), .RD_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .fftdone(fftdone), .ramq1(q_a),
`ifdef FREQ_DETECT_THRESH_EN
        .thresh(thresh), .nodetect(nod_a),
`endif
        .rdaddr1(rd_a), .maxbin(bin_a), .maxpwr(pwr_a), .detectdone(done_a), .busy(busy_a)
    );

    freq_detect #(.BIN_LO(LO), .BIN_HI(HI), .RD_LAT(2)) dut_b (
        .clk(clk), .reset(reset), .fftdone(fftdone), .ramq1(q_b),
`ifdef FREQ_DETECT_THRESH_EN
        .thresh(thresh), .nodetect(nod_b),
`endif
        .rdaddr1(rd_b), .maxbin(bin_b), .maxpwr(pwr_b), .detectdone(done_b), .busy(busy_b)
    );

`ifndef FREQ_DETECT_THRESH_EN
    assign nod_a = 1'b0;
    assign nod_b = 1'b0;
`endif

    // Bench RAMs with one and two cycles of read latency.
    always @(posedge clk) begin
        q_a   <= mem[rd_a];
        q_b_p <= mem[rd_b];
        q_b   <= q_b_p;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic put(input int b, input int re, input int im);
        fr_re[b] = re;
        fr_im[b] = im;
        mem[b]   = {14'(re), 14'(im)};
    endtask

    task automatic fill(input int re, input int im);
        for (int i = 0; i < 1024; i++) put(i, re, im);
    endtask

    // Frame-level expectation: plain search for the first bin of largest power.
    function automatic void frame_max(output int b, output int p);
        b = LO;
        p = 0;
        for (int i = LO; i <= HI; i++) begin
            int pw;
            pw = fr_re[i] * fr_re[i] + fr_im[i] * fr_im[i];
            if (pw > p) begin
                p = pw;
                b = i;
            end
        end
    endfunction

    // Model: a scan accepted at edge E reports at edge E+N+latency, stays busy one more cycle.
    int m_lat [2] = '{1, 2};
    bit m_busy [2];
    bit m_done [2];
    bit m_nod  [2];
    int m_bin [2];
    int m_pwr [2];
    int m_due [2];
    int m_sbin [2];
    int m_spwr [2];
    int edge_n = 0;

    always @(posedge clk) begin
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_busy[k] = 1'b0; m_done[k] = 1'b0; m_nod[k] = 1'b0;
                m_bin[k]  = 0;    m_pwr[k]  = 0;
            end else begin
                m_done[k] = 1'b0;
                m_nod[k]  = 1'b0;
                if (m_busy[k] && edge_n == m_due[k]) begin
                    if (m_spwr[k] >= int'(thresh)) begin
                        m_done[k] = 1'b1;
                        m_bin[k]  = m_sbin[k];
                        m_pwr[k]  = m_spwr[k];
                    end else begin
                        m_nod[k] = 1'b1;
                    end
                end else if (m_busy[k] && edge_n == m_due[k] + 1) begin
                    m_busy[k] = 1'b0;
                end else if (!m_busy[k] && fftdone) begin
                    m_busy[k] = 1'b1;
                    m_due[k]  = edge_n + N + m_lat[k];
                    frame_max(m_sbin[k], m_spwr[k]);
                end
            end
        end
    end

    task automatic cmp_dut(input int k, input logic bz, input logic dn, input logic nd,
                           input logic [9:0] bn, input logic [28:0] pw, input logic [9:0] rd);
        check($sformatf("busy%0d", k), bz, m_busy[k]);
        check($sformatf("detectdone%0d", k), dn, m_done[k]);
        check($sformatf("nodetect%0d", k), nd, m_nod[k]);
        check($sformatf("maxbin%0d", k), bn, m_bin[k]);
        check($sformatf("maxpwr%0d", k), pw, m_pwr[k]);
        if (!m_busy[k] || m_done[k] || m_nod[k])
            check($sformatf("rdaddr1_%0d", k), rd, m_bin[k]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, busy_a, done_a, nod_a, bin_a, pwr_a, rd_a);
            cmp_dut(1, busy_b, done_b, nod_b, bin_b, pwr_b, rd_b);
        end
    end

    // Directed run: fftdone in cycle 0, optional extra pulses / reset at given cycles (0 = none).
    int fa, fb, la, ca, cb, na;

    task automatic run(input int p1, input int p2, input int rst_at, input int ncyc);
        fa = -1; fb = -1; la = -1; ca = 0; cb = 0; na = 0;
        @(posedge clk); #1;
        fftdone = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            fftdone = (c == p1) || (c == p2);
            reset   = (c == rst_at);
            @(negedge clk);
            if (done_a) begin ca++; la = c; if (fa < 0) fa = c; end
            if (done_b) begin cb++; if (fb < 0) fb = c; end
            if (nod_a) na++;
        end
        fftdone = 1'b0;
        reset   = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        fftdone = 1'b0;
        thresh  = '0;
        fill(0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_maxbin", bin_a, 0);
        check("reset_rdaddr1", rd_a, 0);
        check("reset_busy", busy_a, 0);

        // Single tone at bin 100 over a (10,10) floor.
        fill(10, 10);
        put(100, 1000, 0);
        run(0, 0, 0, 520);
        check("tone_latency_lat1", fa, 513);
        check("tone_latency_lat2", fb, 514);
        check("tone_pulses", ca, 1);
        check("tone_maxbin", bin_a, 100);
        check("tone_maxpwr", pwr_a, 1000000);
        check("tone_rdaddr1", rd_a, 100);
        check("tone_maxbin_lat2", bin_b, 100);

        // Re-pulse of fftdone mid-scan is ignored.
        run(200, 0, 0, 520);
        check("repulse_latency", fa, 513);
        check("repulse_pulses", ca, 1);

        // Tie: lowest bin wins.
        fill(0, 0);
        put(40, 0, -2000);
        put(300, 0, -2000);
        run(0, 0, 0, 520);
        check("tie_maxbin", bin_a, 40);
        check("tie_maxpwr", pwr_a, 4000000);

        // Most negative corner.
        fill(0, 0);
        put(7, -8192, -8192);
        put(8, 8191, -8192);
        put(9, -8192, 0);
        run(0, 0, 0, 520);
        check("ext_maxbin", bin_a, 7);
        check("ext_maxpwr", pwr_a, 134217728);
        check("ext_maxpwr_lat2", pwr_b, 134217728);

        // Bins outside BIN_LO..BIN_HI do not count.
        fill(0, 0);
        put(0, 8191, 8191);
        put(600, 8191, 8191);
        put(5, 100, 0);
        run(0, 0, 0, 520);
        check("range_maxbin", bin_a, 5);
        check("range_maxpwr", pwr_a, 10000);

        // All-zero frame.
        fill(0, 0);
        run(0, 0, 0, 520);
        check("zero_maxbin", bin_a, 1);
        check("zero_maxpwr", pwr_a, 0);

`ifdef FREQ_DETECT_THRESH_EN
        fill(10, 10);
        put(100, 1000, 0);
        thresh = 29'd5000000;
        run(0, 0, 0, 520);
        check("thr_hi_detect", ca, 0);
        check("thr_hi_nodetect", na, 1);
        check("thr_hi_maxbin", bin_a, 1);
        thresh = 29'd500000;
        run(0, 0, 0, 520);
        check("thr_lo_detect", ca, 1);
        check("thr_lo_maxbin", bin_a, 100);
        thresh = '0;
`endif

        // fftdone in the detectdone cycle is dropped; the next cycle starts a new scan.
        fill(10, 10);
        put(100, 1000, 0);
        run(513, 514, 0, 1045);
        check("chain_first", fa, 513);
        check("chain_pulses_lat1", ca, 2);
        check("chain_second", la, 1027);
        check("chain_pulses_lat2", cb, 1);

        // Reset mid-scan aborts with no detectdone and clears outputs.
        run(0, 0, 300, 600);
        check("rst_pulses", ca + cb, 0);
        check("rst_maxbin", bin_a, 0);
        check("rst_maxpwr", pwr_a, 0);
        check("rst_rdaddr1", rd_a, 0);
        check("rst_busy", busy_b, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
